mux8_rr_arbiter: RTL

//  Round-robin arbiter/scheduler sharing one WIDTH-bit 8:1 datapath (mux8_1_wide) among 8 requesters.

---
 rtl/mux8_rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 wide datapath among eight requesters,
// with burst locking and a single registered valid/ready output slot.

module mux8_1_wide #(
  parameter int WIDTH = 64
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in [0:7],
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (sel)
      3'd0: out = in[0];
      3'd1: out = in[1];
      3'd2: out = in[2];
      3'd3: out = in[3];
      3'd4: out = in[4];
      3'd5: out = in[5];
      3'd6: out = in[6];
      3'd7: out = in[7];
      default: out = '0;
    endcase
  end

endmodule

module mux8_rr_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] in [0:7],
  input  logic [7:0]       last,
  output logic [7:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_src,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       owner;

  logic [2:0]       winner_p0;
  logic             found_p0;
  logic [2:0]       sel_p0;
  logic             req_ok_p0;
  logic             load_p0;
  logic             fire_p0;
  logic             last_sel_p0;
  logic [WIDTH-1:0] mux_data_p0;

  // Scan ptr, ptr+1, ... ptr+7 (mod 8); descending loop lets the lowest offset win.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] pick;
    logic [2:0] idx;
    pick = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  // Stage p0: arbitration and datapath select (combinational)
  always_comb begin
    {found_p0, winner_p0} = rr_pick(req, ptr);
  end

  always_comb begin
    sel_p0      = (state == LOCKED) ? owner : winner_p0;
    req_ok_p0   = (state == LOCKED) ? req[owner] : found_p0;
    load_p0     = !out_valid || out_ready;
    fire_p0     = !reset && load_p0 && req_ok_p0;
    last_sel_p0 = last[sel_p0];
  end

  mux8_1_wide #(.WIDTH(WIDTH)) u_mux (
    .sel (sel_p0),
    .in  (in),
    .out (mux_data_p0)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire_p0 && !last_sel_p0) state_nxt = LOCKED;
      LOCKED:  if (fire_p0 &&  last_sel_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    gnt  = fire_p0 ? (8'd1 << sel_p0) : 8'h00;
    busy = (state == LOCKED);
  end

  // Round-robin pointer advances past a requester only when its burst ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= 3'd0;
      owner <= 3'd0;
    end else if (fire_p0) begin
      if (last_sel_p0)          ptr   <= sel_p0 + 3'd1;
      else if (state == IDLE)   owner <= sel_p0;
    end
  end

  // Stage p1: output slot; a drain and a new load may share one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 3'd0;
      out_last  <= 1'b0;
    end else if (fire_p0) begin
      out_valid <= 1'b1;
      out_data  <= mux_data_p0;
      out_src   <= sel_p0;
      out_last  <= last_sel_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
